// File: rtl/brick_move_ctrl.sv
// Move controller for the active brick: spawn, candidate moves, collision
// verdicts from an external checker, commit or reject, and lock into the board.
`ifndef POS_LEN
`define POS_LEN 8
`endif
`ifndef DIR_LEN
`define DIR_LEN 2
`endif
`ifndef BRICK_LEN
`define BRICK_LEN 3
`endif
// Position is {row[7:4], col[3:0]}; down means the next row.
`ifndef POS_LEFT
`define POS_LEFT(p) {p[7:4], p[3:0] - 4'd1}
`endif
`ifndef POS_RIGHT
`define POS_RIGHT(p) {p[7:4], p[3:0] + 4'd1}
`endif
`ifndef POS_DOWN
`define POS_DOWN(p) {p[7:4] + 4'd1, p[3:0]}
`endif

module brick_move_ctrl #(
    parameter logic [`POS_LEN-1:0] SPAWN_POS = '0,
    parameter logic [`DIR_LEN-1:0] SPAWN_DIR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spawn,
    input  logic [`BRICK_LEN-1:0] spawn_type,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd,
    output logic                  cmd_ready,
    output logic [`POS_LEN-1:0]   cand_pos,
    output logic [`DIR_LEN-1:0]   cand_dir,
    output logic [`BRICK_LEN-1:0] cand_type,
    input  logic                  is_collided,
    output logic [`POS_LEN-1:0]   cur_pos,
    output logic [`DIR_LEN-1:0]   cur_dir,
    output logic [`BRICK_LEN-1:0] cur_type,
    output logic                  active,
    output logic                  cmd_done,
    output logic                  cmd_ok,
    output logic                  lock_valid,
    output logic                  game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN_CHK,
        S_READY,
        S_MOVE_CHK,
        S_LOCK,
        S_OVER
    } state_t;

    localparam logic [1:0] CMD_LEFT  = 2'd0;
    localparam logic [1:0] CMD_RIGHT = 2'd1;
    localparam logic [1:0] CMD_ROT   = 2'd2;
    localparam logic [1:0] CMD_DOWN  = 2'd3;

    state_t                  r_state;
    logic [1:0]              r_cmd;
    logic [`POS_LEN-1:0]     r_cand_pos;
    logic [`DIR_LEN-1:0]     r_cand_dir;
    logic [`BRICK_LEN-1:0]   r_cand_type;
    logic [`POS_LEN-1:0]     r_cur_pos;
    logic [`DIR_LEN-1:0]     r_cur_dir;
    logic [`BRICK_LEN-1:0]   r_cur_type;
    logic                    r_active;
    logic                    r_cmd_ready;
    logic                    r_cmd_done;
    logic                    r_cmd_ok;
    logic                    r_lock_valid;
    logic                    r_game_over;

    logic [`POS_LEN-1:0]     w_nxt_pos;
    logic [`DIR_LEN-1:0]     w_nxt_dir;

    always_comb begin
        w_nxt_pos = r_cur_pos;
        w_nxt_dir = r_cur_dir;
        unique case (cmd)
            CMD_LEFT:  w_nxt_pos = `POS_LEFT(r_cur_pos);
            CMD_RIGHT: w_nxt_pos = `POS_RIGHT(r_cur_pos);
            CMD_ROT:   w_nxt_dir = r_cur_dir + 1'b1;
            CMD_DOWN:  w_nxt_pos = `POS_DOWN(r_cur_pos);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_cand_pos   <= '0;
            r_cand_dir   <= '0;
            r_cand_type  <= '0;
            r_cur_pos    <= '0;
            r_cur_dir    <= '0;
            r_cur_type   <= '0;
            r_active     <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_cmd_done   <= 1'b0;
            r_cmd_ok     <= 1'b0;
            r_lock_valid <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_cmd_done   <= 1'b0;
            r_lock_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Holds through the lock_valid cycle, then drops.
                    r_active <= 1'b0;
                    if (spawn) begin
                        r_cand_pos  <= SPAWN_POS;
                        r_cand_dir  <= SPAWN_DIR;
                        r_cand_type <= spawn_type;
                        r_state     <= S_SPAWN_CHK;
                    end
                end
                S_SPAWN_CHK: begin
                    if (is_collided) begin
                        r_game_over <= 1'b1;
                        r_cand_pos  <= r_cur_pos;
                        r_cand_dir  <= r_cur_dir;
                        r_cand_type <= r_cur_type;
                        r_state     <= S_OVER;
                    end else begin
                        r_cur_pos   <= r_cand_pos;
                        r_cur_dir   <= r_cand_dir;
                        r_cur_type  <= r_cand_type;
                        r_active    <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_READY;
                    end
                end
                S_READY: begin
                    if (cmd_valid) begin
                        r_cand_pos  <= w_nxt_pos;
                        r_cand_dir  <= w_nxt_dir;
                        r_cmd       <= cmd;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_MOVE_CHK;
                    end
                end
                S_MOVE_CHK: begin
                    r_cmd_done <= 1'b1;
                    if (!is_collided) begin
                        r_cur_pos   <= r_cand_pos;
                        r_cur_dir   <= r_cand_dir;
                        r_cmd_ok    <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_READY;
                    end else begin
                        r_cand_pos <= r_cur_pos;
                        r_cand_dir <= r_cur_dir;
                        r_cmd_ok   <= 1'b0;
                        if (r_cmd == CMD_DOWN) begin
                            r_state <= S_LOCK;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_READY;
                        end
                    end
                end
                S_LOCK: begin
                    r_lock_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign cand_pos   = r_cand_pos;
    assign cand_dir   = r_cand_dir;
    assign cand_type  = r_cand_type;
    assign cur_pos    = r_cur_pos;
    assign cur_dir    = r_cur_dir;
    assign cur_type   = r_cur_type;
    assign active     = r_active;
    assign cmd_done   = r_cmd_done;
    assign cmd_ok     = r_cmd_ok;
    assign lock_valid = r_lock_valid;
    assign game_over  = r_game_over;

endmodule
